// File: rtl/demux_1_to_n_stream.sv
// Registered 1:N stream demux: one-entry holding register per lane, unicast or broadcast, 1-cycle latency.
// in_ready is combinational from out_ready/in_sel; a stalled lane only blocks words addressed to it.
module demux_1_to_n_stream #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 8,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_bcast,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic [N_CH-1:0]        out_valid,
    input  logic [N_CH-1:0]        out_ready,
    output logic                   sel_err,
    output logic [15:0]            drop_cnt
);

    logic [DATA_W-1:0] buf_q [N_CH];
    logic [DATA_W-1:0] buf_d [N_CH];
    logic [N_CH-1:0]   v_q, v_d;
    logic [N_CH-1:0]   free;
    logic [N_CH-1:0]   load;
    logic              sel_ok;
    logic              accept;
    logic              drop;
    logic              sel_err_q;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    // With a power-of-two lane count every select value names a real lane.
    if (N_CH == (1 << SEL_W)) begin : g_sel_full
        assign sel_ok = 1'b1;
    end else begin : g_sel_part
        assign sel_ok = (in_sel < SEL_W'(N_CH));
    end

    assign free = ~v_q | out_ready;

    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &free;
        end else if (sel_ok) begin
            in_ready = free[in_sel];
        end
    end

    assign accept = in_valid & in_ready;
    assign drop   = accept & ~in_bcast & ~sel_ok;

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        assign load[i] = accept & (in_bcast | (sel_ok & (in_sel == SEL_W'(i))));
        assign out_data[i*DATA_W +: DATA_W] = v_q[i] ? buf_q[i] : '0;
    end

    always_comb begin
        v_d   = v_q;
        buf_d = buf_q;
        for (int i = 0; i < N_CH; i++) begin
            if (load[i]) begin
                buf_d[i] = in_data;
                v_d[i]   = 1'b1;
            end else if (v_q[i] && out_ready[i]) begin
                v_d[i]   = 1'b0;
            end
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q        <= '0;
            sel_err_q  <= 1'b0;
            drop_cnt_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            v_q        <= v_d;
            buf_q      <= buf_d;
            sel_err_q  <= drop;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign out_valid = v_q;
    assign sel_err   = sel_err_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_1_to_n_stream.sv
// Directed and scoreboarded bench for demux_1_to_n_stream across four parameter sets.
module tb_demux_1_to_n_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 8 lanes x 8 bits
    logic [7:0]  a_in_data;
    logic [2:0]  a_in_sel;
    logic        a_in_bcast, a_in_valid, a_in_ready, a_sel_err;
    logic [63:0] a_out_data;
    logic [7:0]  a_out_valid, a_out_ready;
    logic [15:0] a_drop_cnt;

    // 6 lanes x 8 bits (non power of two)
    logic [7:0]  b_in_data;
    logic [2:0]  b_in_sel;
    logic        b_in_bcast, b_in_valid, b_in_ready, b_sel_err;
    logic [47:0] b_out_data;
    logic [5:0]  b_out_valid, b_out_ready;
    logic [15:0] b_drop_cnt;

    // 2 lanes x 8 bits
    logic [7:0]  c_in_data;
    logic [0:0]  c_in_sel;
    logic        c_in_bcast, c_in_valid, c_in_ready, c_sel_err;
    logic [15:0] c_out_data;
    logic [1:0]  c_out_valid, c_out_ready;
    logic [15:0] c_drop_cnt;

    // 16 lanes x 32 bits
    logic [31:0]  e_in_data;
    logic [3:0]   e_in_sel;
    logic         e_in_bcast, e_in_valid, e_in_ready, e_sel_err;
    logic [511:0] e_out_data;
    logic [15:0]  e_out_valid, e_out_ready;
    logic [15:0]  e_drop_cnt;

    demux_1_to_n_stream #(.DATA_W(8), .N_CH(8)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_sel(a_in_sel), .in_bcast(a_in_bcast),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .sel_err(a_sel_err), .drop_cnt(a_drop_cnt));

    demux_1_to_n_stream #(.DATA_W(8), .N_CH(6)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_sel(b_in_sel), .in_bcast(b_in_bcast),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .sel_err(b_sel_err), .drop_cnt(b_drop_cnt));

    demux_1_to_n_stream #(.DATA_W(8), .N_CH(2)) dut_c (
        .clk(clk), .rst(rst), .in_data(c_in_data), .in_sel(c_in_sel), .in_bcast(c_in_bcast),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .sel_err(c_sel_err), .drop_cnt(c_drop_cnt));

    demux_1_to_n_stream #(.DATA_W(32), .N_CH(16)) dut_e (
        .clk(clk), .rst(rst), .in_data(e_in_data), .in_sel(e_in_sel), .in_bcast(e_in_bcast),
        .in_valid(e_in_valid), .in_ready(e_in_ready), .out_data(e_out_data), .out_valid(e_out_valid),
        .out_ready(e_out_ready), .sel_err(e_sel_err), .drop_cnt(e_drop_cnt));

    logic [31:0] sb_q [16][$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (a_out_valid !== 8'h00) begin n_fail++; $display("FAIL reset_valid: got %h expected 00", a_out_valid); end
        n_checks++; if (a_out_data !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", a_out_data); end
        n_checks++; if (a_sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err: got %b expected 0", a_sel_err); end
        n_checks++; if (a_drop_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_drop_cnt: got %h expected 0", a_drop_cnt); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        a_out_ready = 8'hF7;
        a_in_valid  = 1'b1; a_in_sel = 3'd3; a_in_data = 8'h3C;
        tick();
        a_in_valid = 1'b0;
        n_checks++; if (a_out_valid !== 8'h08) begin n_fail++; $display("FAIL reset_preload: got %h expected 08", a_out_valid); end
        rst = 1'b1;
        #1;
        n_checks++; if (a_out_valid !== 8'h00) begin n_fail++; $display("FAIL reset_mid_valid: got %h expected 00", a_out_valid); end
        n_checks++; if (a_out_data !== 64'h0) begin n_fail++; $display("FAIL reset_mid_data: got %h expected 0", a_out_data); end
        tick();
        rst = 1'b0;
        a_in_bcast = 1'b1;
        tick();
        n_checks++; if (a_drop_cnt !== 16'h0) begin n_fail++; $display("FAIL release_drop_cnt: got %h expected 0", a_drop_cnt); end
        n_checks++; if (a_sel_err !== 1'b0) begin n_fail++; $display("FAIL release_sel_err: got %b expected 0", a_sel_err); end
        n_checks++; if (a_out_valid !== 8'h00) begin n_fail++; $display("FAIL idle_bcast_no_load: got %h expected 00", a_out_valid); end
        a_in_bcast  = 1'b0;
        a_out_ready = 8'hFF;
    endtask

    task automatic test_unicast();
        logic [7:0]  expd;
        logic [63:0] expo;
        for (int i = 0; i < 8; i++) begin
            expd = 8'(8'hA0 + i);
            a_in_valid = 1'b1; a_in_sel = 3'(i); a_in_data = expd;
            #1;
            n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL unicast_ready[%0d]: got %b expected 1", i, a_in_ready); end
            tick();
            expo = 64'(expd) << (8 * i);
            n_checks++; if (a_out_valid !== 8'(1 << i)) begin n_fail++; $display("FAIL unicast_valid[%0d]: got %h expected %h", i, a_out_valid, 8'(1 << i)); end
            n_checks++; if (a_out_data !== expo) begin n_fail++; $display("FAIL unicast_data[%0d]: got %h expected %h", i, a_out_data, expo); end
        end
        a_in_valid = 1'b0;
        tick();
        n_checks++; if (a_out_valid !== 8'h00) begin n_fail++; $display("FAIL unicast_drain: got %h expected 00", a_out_valid); end
    endtask

    task automatic test_backpressure();
        a_out_ready = 8'hFB;
        a_in_valid = 1'b1; a_in_sel = 3'd2; a_in_data = 8'h11;
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready: got %b expected 1", a_in_ready); end
        tick();
        n_checks++; if (a_out_data !== 64'h0000_0000_0011_0000) begin n_fail++; $display("FAIL bp_first_data: got %h expected 0000000000110000", a_out_data); end
        a_in_data = 8'h22;
        #1;
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready: got %b expected 0", a_in_ready); end
        tick();
        n_checks++; if (a_out_valid !== 8'h04) begin n_fail++; $display("FAIL bp_hold_valid: got %h expected 04", a_out_valid); end
        n_checks++; if (a_out_data !== 64'h0000_0000_0011_0000) begin n_fail++; $display("FAIL bp_hold_data: got %h expected 0000000000110000", a_out_data); end
        a_in_sel = 3'd5; a_in_data = 8'h33;
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_other_ready: got %b expected 1", a_in_ready); end
        tick();
        n_checks++; if (a_out_valid !== 8'h24) begin n_fail++; $display("FAIL bp_other_valid: got %h expected 24", a_out_valid); end
        n_checks++; if (a_out_data !== 64'h0000_3300_0011_0000) begin n_fail++; $display("FAIL bp_other_data: got %h expected 0000330000110000", a_out_data); end
        a_in_sel = 3'd2; a_in_data = 8'h22;
        #1;
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_restall_ready: got %b expected 0", a_in_ready); end
        a_out_ready = 8'hFF;
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", a_in_ready); end
        tick();
        n_checks++; if (a_out_valid !== 8'h04) begin n_fail++; $display("FAIL bp_release_valid: got %h expected 04", a_out_valid); end
        n_checks++; if (a_out_data !== 64'h0000_0000_0022_0000) begin n_fail++; $display("FAIL bp_release_data: got %h expected 0000000000220000", a_out_data); end
        a_in_valid = 1'b0;
        tick();
        n_checks++; if (a_out_valid !== 8'h00) begin n_fail++; $display("FAIL bp_drain: got %h expected 00", a_out_valid); end
    endtask

    task automatic test_broadcast();
        a_out_ready = 8'hBF;
        a_in_valid = 1'b1; a_in_sel = 3'd6; a_in_data = 8'h66; a_in_bcast = 1'b0;
        tick();
        a_in_bcast = 1'b1; a_in_data = 8'h5A; a_in_sel = 3'd1;
        #1;
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bcast_blocked_ready: got %b expected 0", a_in_ready); end
        tick();
        n_checks++; if (a_out_valid !== 8'h40) begin n_fail++; $display("FAIL bcast_no_partial: got %h expected 40", a_out_valid); end
        n_checks++; if (a_out_data !== 64'h0066_0000_0000_0000) begin n_fail++; $display("FAIL bcast_hold_data: got %h expected 0066000000000000", a_out_data); end
        a_out_ready = 8'hFF;
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bcast_free_ready: got %b expected 1", a_in_ready); end
        tick();
        n_checks++; if (a_out_valid !== 8'hFF) begin n_fail++; $display("FAIL bcast_valid: got %h expected ff", a_out_valid); end
        n_checks++; if (a_out_data !== 64'h5A5A_5A5A_5A5A_5A5A) begin n_fail++; $display("FAIL bcast_data: got %h expected 5a5a5a5a5a5a5a5a", a_out_data); end
        a_in_valid = 1'b0; a_in_bcast = 1'b0;
        tick();
        n_checks++; if (a_out_valid !== 8'h00) begin n_fail++; $display("FAIL bcast_drain: got %h expected 00", a_out_valid); end
    endtask

    task automatic test_invalid_sel();
        b_out_ready = 6'h3F;
        b_in_valid = 1'b1; b_in_sel = 3'd6; b_in_data = 8'hEE;
        #1;
        n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL badsel_ready: got %b expected 1", b_in_ready); end
        tick();
        n_checks++; if (b_sel_err !== 1'b1) begin n_fail++; $display("FAIL badsel_err1: got %b expected 1", b_sel_err); end
        n_checks++; if (b_drop_cnt !== 16'd1) begin n_fail++; $display("FAIL badsel_cnt1: got %h expected 0001", b_drop_cnt); end
        b_in_sel = 3'd7;
        tick();
        n_checks++; if (b_sel_err !== 1'b1) begin n_fail++; $display("FAIL badsel_err2: got %b expected 1", b_sel_err); end
        n_checks++; if (b_drop_cnt !== 16'd2) begin n_fail++; $display("FAIL badsel_cnt2: got %h expected 0002", b_drop_cnt); end
        n_checks++; if (b_out_valid !== 6'h00) begin n_fail++; $display("FAIL badsel_no_valid: got %h expected 00", b_out_valid); end
        b_in_valid = 1'b0;
        tick();
        n_checks++; if (b_sel_err !== 1'b0) begin n_fail++; $display("FAIL badsel_err_clear: got %b expected 0", b_sel_err); end
        n_checks++; if (b_drop_cnt !== 16'd2) begin n_fail++; $display("FAIL badsel_cnt_hold: got %h expected 0002", b_drop_cnt); end
        b_in_valid = 1'b1;
        repeat (65532) tick();
        b_in_valid = 1'b0;
        tick();
        n_checks++; if (b_drop_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL badsel_cnt_fffe: got %h expected fffe", b_drop_cnt); end
        b_in_valid = 1'b1;
        tick();
        n_checks++; if (b_drop_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL badsel_cnt_ffff: got %h expected ffff", b_drop_cnt); end
        repeat (2) tick();
        n_checks++; if (b_drop_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL badsel_cnt_sat: got %h expected ffff", b_drop_cnt); end
        n_checks++; if (b_sel_err !== 1'b1) begin n_fail++; $display("FAIL badsel_err_sat: got %b expected 1", b_sel_err); end
        b_in_valid = 1'b0;
        tick();
        n_checks++; if (b_drop_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL badsel_cnt_stay: got %h expected ffff", b_drop_cnt); end
    endtask

    task automatic test_sweep(input int which);
        int          nch;
        logic [15:0] rdy, ov;
        logic [31:0] d, lane, expv;
        logic [3:0]  s;
        logic        bc, vld, irdy, hold;
        nch = (which == 0) ? 2 : 16;
        hold = 1'b0; vld = 1'b0; bc = 1'b0; s = '0; d = '0;
        for (int l = 0; l < 16; l++) sb_q[l].delete();
        for (int cyc = 0; cyc < 460; cyc++) begin
            rdy = 16'($urandom);
            if (cyc >= 400) begin
                rdy = 16'hFFFF; vld = 1'b0; hold = 1'b0;
            end else if (!hold) begin
                vld = ($urandom_range(0, 3) != 0);
                s   = 4'($urandom_range(0, nch - 1));
                d   = $urandom;
                if (which == 0) d[31:8] = '0;
                bc  = ($urandom_range(0, 15) == 0);
            end
            if (which == 0) begin
                c_out_ready = rdy[1:0]; c_in_valid = vld; c_in_sel = s[0]; c_in_data = d[7:0]; c_in_bcast = bc;
            end else begin
                e_out_ready = rdy; e_in_valid = vld; e_in_sel = s; e_in_data = d; e_in_bcast = bc;
            end
            #1;
            irdy = (which == 0) ? c_in_ready : e_in_ready;
            ov   = (which == 0) ? {14'b0, c_out_valid} : e_out_valid;
            for (int l = 0; l < nch; l++) begin
                if (ov[l] && rdy[l]) begin
                    lane = (which == 0) ? {24'b0, c_out_data[l*8 +: 8]} : e_out_data[l*32 +: 32];
                    n_checks++;
                    if (sb_q[l].size() == 0) begin
                        n_fail++; $display("FAIL sweep%0d_extra lane %0d: got %h expected no word", which, l, lane);
                    end else begin
                        expv = sb_q[l].pop_front();
                        if (lane !== expv) begin
                            n_fail++; $display("FAIL sweep%0d_data lane %0d: got %h expected %h", which, l, lane, expv);
                        end
                    end
                end
            end
            if (vld && irdy) begin
                for (int l = 0; l < nch; l++) begin
                    if (bc || (32'(s) == l)) sb_q[l].push_back(d);
                end
            end
            hold = vld && !irdy;
            tick();
        end
        for (int l = 0; l < nch; l++) begin
            n_checks++;
            if (sb_q[l].size() != 0) begin
                n_fail++; $display("FAIL sweep%0d_lost lane %0d: got %0d pending expected 0", which, l, sb_q[l].size());
            end
        end
        c_in_valid = 1'b0; e_in_valid = 1'b0; c_in_bcast = 1'b0; e_in_bcast = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_in_data = '0; a_in_sel = '0; a_in_bcast = 1'b0; a_in_valid = 1'b0; a_out_ready = '1;
        b_in_data = '0; b_in_sel = '0; b_in_bcast = 1'b0; b_in_valid = 1'b0; b_out_ready = '1;
        c_in_data = '0; c_in_sel = '0; c_in_bcast = 1'b0; c_in_valid = 1'b0; c_out_ready = '1;
        e_in_data = '0; e_in_sel = '0; e_in_bcast = 1'b0; e_in_valid = 1'b0; e_out_ready = '1;
        test_reset();
        test_unicast();
        test_backpressure();
        test_broadcast();
        test_invalid_sel();
        test_sweep(0);
        test_sweep(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
